// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multi-cycle RV32I controller: opcodes, FSM states,
// ALU op classes and datapath mux-select codes.
package riscv_pkg;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        JAL      = 4'd9,
        BEQ      = 4'd10
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD  = 2'b00,
        ALUOP_SUB  = 2'b01,
        ALUOP_FUNC = 2'b10
    } aluop_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] SRC_A_PC    = 2'b00;
    localparam logic [1:0] SRC_A_OLDPC = 2'b01;
    localparam logic [1:0] SRC_A_RS1   = 2'b10;

    localparam logic [1:0] SRC_B_RS2  = 2'b00;
    localparam logic [1:0] SRC_B_IMM  = 2'b01;
    localparam logic [1:0] SRC_B_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    // R-type has no immediate; it falls back to the I format like any other opcode.
    function automatic logic [1:0] imm_src_of(input logic [6:0] opcode);
        case (opcode)
            OP_SW:   return IMM_S;
            OP_BEQ:  return IMM_B;
            OP_JAL:  return IMM_J;
            default: return IMM_I;
        endcase
    endfunction

    function automatic logic is_supported(input logic [6:0] opcode);
        case (opcode)
            OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_BEQ: return 1'b1;
            default:                                  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath bundle: instruction fields and status in, selects and enables out.
interface multicycle_ctrl_if;

    logic [6:0] opcode;
    logic [2:0] fun3;
    logic       fun7;
    logic       zero;
    logic       mem_ready;

    logic       pc_write;
    logic       ir_write;
    logic       adr_src;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] imm_src;
    logic [2:0] alu_control;
    logic       instr_done;
    logic       illegal;

    modport master (
        input  opcode, fun3, fun7, zero, mem_ready,
        output pc_write, ir_write, adr_src, mem_write, reg_write,
               result_src, alu_src_a, alu_src_b, imm_src, alu_control,
               instr_done, illegal
    );

    modport slave (
        output opcode, fun3, fun7, zero, mem_ready,
        input  pc_write, ir_write, adr_src, mem_write, reg_write,
               result_src, alu_src_a, alu_src_b, imm_src, alu_control,
               instr_done, illegal
    );

endinterface

// File: rtl/multicycle_ctrl_alu_op_dec.sv
// Maps the FSM's ALU op class plus instruction function bits to the ALU control code.
module alu_op_dec
    import riscv_pkg::*;
(
    input  aluop_t     aluop,
    input  logic [2:0] fun3,
    input  logic       fun7,
    input  logic       op5,
    output logic [2:0] alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (aluop)
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNC: begin
                case (fun3)
                    // Only R-type (op5=1) may subtract; addi with imm[10]=1 must still add.
                    3'b000:  alu_control = (op5 && fun7) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM driving a shared-ALU/shared-memory datapath.
//   state    | meaning
//   FETCH    | read instr at PC, PC+4 -> PC (waits on mem_ready)
//   DECODE   | oldPC+imm -> ALUOut, dispatch on opcode
//   MEMADR   | rs1+imm -> ALUOut
//   MEMREAD  | load from ALUOut (waits on mem_ready)
//   MEMWB    | mem data -> rd
//   MEMWRITE | store to ALUOut (waits on mem_ready)
//   EXECR    | rs1 op rs2
//   EXECI    | rs1 op imm
//   ALUWB    | ALUOut -> rd
//   JAL      | target -> PC, oldPC+4 -> ALUOut
//   BEQ      | rs1-rs2, take branch when zero
module multicycle_ctrl
    import riscv_pkg::*;
#(
    parameter bit MEM_HANDSHAKE = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    multicycle_ctrl_if.master   bus
);

    state_t     state;
    aluop_t     aluop;
    logic       ready;
    logic       pc_write;
    logic       ir_write;
    logic       adr_src;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic       instr_done;
    logic       illegal;
    logic [2:0] alu_control;

    assign ready = MEM_HANDSHAKE ? bus.mem_ready : 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= FETCH;
        end else begin
            case (state)
                FETCH:    if (ready) state <= DECODE;
                DECODE: begin
                    case (bus.opcode)
                        OP_LW, OP_SW: state <= MEMADR;
                        OP_R:         state <= EXECR;
                        OP_I:         state <= EXECI;
                        OP_JAL:       state <= JAL;
                        OP_BEQ:       state <= BEQ;
                        default:      state <= FETCH;
                    endcase
                end
                MEMADR:   state <= bus.opcode[5] ? MEMWRITE : MEMREAD;
                MEMREAD:  if (ready) state <= MEMWB;
                MEMWB:    state <= FETCH;
                MEMWRITE: if (ready) state <= FETCH;
                EXECR:    state <= ALUWB;
                EXECI:    state <= ALUWB;
                ALUWB:    state <= FETCH;
                JAL:      state <= ALUWB;
                BEQ:      state <= FETCH;
                default:  state <= FETCH;
            endcase
        end
    end

    always_comb begin
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        adr_src    = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        result_src = RES_ALUOUT;
        alu_src_a  = SRC_A_PC;
        alu_src_b  = SRC_B_RS2;
        aluop      = ALUOP_ADD;
        instr_done = 1'b0;
        illegal    = 1'b0;
        case (state)
            FETCH: begin
                result_src = RES_ALU;
                alu_src_b  = SRC_B_FOUR;
                pc_write   = ready;
                ir_write   = ready;
            end
            DECODE: begin
                alu_src_a = SRC_A_OLDPC;
                alu_src_b = SRC_B_IMM;
                if (!is_supported(bus.opcode)) begin
                    illegal    = 1'b1;
                    instr_done = 1'b1;
                end
            end
            MEMADR: begin
                alu_src_a = SRC_A_RS1;
                alu_src_b = SRC_B_IMM;
            end
            MEMREAD: adr_src = 1'b1;
            MEMWB: begin
                result_src = RES_MEM;
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            // The strobe stays up through wait states; only completion waits on ready.
            MEMWRITE: begin
                adr_src    = 1'b1;
                mem_write  = 1'b1;
                instr_done = ready;
            end
            EXECR: begin
                alu_src_a = SRC_A_RS1;
                alu_src_b = SRC_B_RS2;
                aluop     = ALUOP_FUNC;
            end
            EXECI: begin
                alu_src_a = SRC_A_RS1;
                alu_src_b = SRC_B_IMM;
                aluop     = ALUOP_FUNC;
            end
            ALUWB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            JAL: begin
                alu_src_a = SRC_A_OLDPC;
                alu_src_b = SRC_B_FOUR;
                pc_write  = 1'b1;
            end
            BEQ: begin
                alu_src_a  = SRC_A_RS1;
                alu_src_b  = SRC_B_RS2;
                aluop      = ALUOP_SUB;
                pc_write   = bus.zero;
                instr_done = 1'b1;
            end
            default: ;
        endcase
        // Reset must abort with no architectural write, whatever state we are in.
        if (!rst_n) begin
            pc_write   = 1'b0;
            ir_write   = 1'b0;
            mem_write  = 1'b0;
            reg_write  = 1'b0;
            instr_done = 1'b0;
            illegal    = 1'b0;
        end
    end

    alu_op_dec u_alu_op_dec (
        .aluop       (aluop),
        .fun3        (bus.fun3),
        .fun7        (bus.fun7),
        .op5         (bus.opcode[5]),
        .alu_control (alu_control)
    );

    assign bus.pc_write    = pc_write;
    assign bus.ir_write    = ir_write;
    assign bus.adr_src     = adr_src;
    assign bus.mem_write   = mem_write;
    assign bus.reg_write   = reg_write;
    assign bus.result_src  = result_src;
    assign bus.alu_src_a   = alu_src_a;
    assign bus.alu_src_b   = alu_src_b;
    assign bus.imm_src     = imm_src_of(bus.opcode);
    assign bus.alu_control = alu_control;
    assign bus.instr_done  = instr_done;
    assign bus.illegal     = illegal;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Cycle-accurate scoreboard bench for multicycle_ctrl: each driven cycle pushes the
// expected output vector, the negedge checker pops and compares it.
module tb_multicycle_ctrl;

    logic clk = 1'b0;
    logic rst_n;

    multicycle_ctrl_if bus ();

    multicycle_ctrl #(.MEM_HANDSHAKE(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [17:0] exp;
    } sb_t;

    sb_t sb[$];
    int  n_chk  = 0;
    int  n_fail = 0;
    logic [1:0] im;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // {pc_write, ir_write, adr_src, mem_write, reg_write, result_src, a, b, imm_src, alu_control, instr_done, illegal}
    function automatic logic [17:0] ev(input logic pc, ir, adr, mw, rw,
                                       input logic [1:0] rs, a, b,
                                       input logic [2:0] alu,
                                       input logic done, ill);
        return {pc, ir, adr, mw, rw, rs, a, b, im, alu, done, ill};
    endfunction

    function automatic logic [17:0] e_fetch(input logic rdy);
        return ev(rdy, rdy, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 0, 0);
    endfunction
    function automatic logic [17:0] e_decode();
        return ev(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 0, 0);
    endfunction
    function automatic logic [17:0] e_memadr();
        return ev(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 0, 0);
    endfunction
    function automatic logic [17:0] e_aluwb();
        return ev(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 1, 0);
    endfunction

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            sb_t e;
            e = sb.pop_front();
            chk(e.tag,
                {14'd0, bus.pc_write, bus.ir_write, bus.adr_src, bus.mem_write, bus.reg_write,
                 bus.result_src, bus.alu_src_a, bus.alu_src_b, bus.imm_src, bus.alu_control,
                 bus.instr_done, bus.illegal},
                {14'd0, e.exp});
        end
    end

    task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                             input logic [1:0] imm_exp);
        bus.opcode = op;
        bus.fun3   = f3;
        bus.fun7   = f7;
        im         = imm_exp;
    endtask

    task automatic step(input string tag, input logic rst, input logic rdy, input logic z,
                        input logic [17:0] exp);
        sb_t e;
        rst_n         = rst;
        bus.mem_ready = rdy;
        bus.zero      = z;
        e.tag = tag;
        e.exp = exp;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic run_alu(input string tag, input logic [6:0] op, input logic [2:0] f3,
                           input logic f7, input logic [2:0] alu_exp);
        logic [1:0] b_exp;
        b_exp = op[5] ? 2'b00 : 2'b01;
        set_instr(op, f3, f7, 2'b00);
        step({tag, "_fetch"},  1, 1, 0, e_fetch(1));
        step({tag, "_decode"}, 1, 1, 0, e_decode());
        step({tag, "_exec"},   1, 1, 0, ev(0, 0, 0, 0, 0, 2'b00, 2'b10, b_exp, alu_exp, 0, 0));
        step({tag, "_wb"},     1, 1, 0, e_aluwb());
    endtask

    initial begin
        rst_n = 1'b0;
        set_instr(7'b0110011, 3'b000, 1'b0, 2'b00);
        bus.mem_ready = 1'b1;
        bus.zero      = 1'b0;
        @(posedge clk);
        #1;
        step("reset_hold", 0, 1, 0, ev(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 0, 0));

        run_alu("r_add",  7'b0110011, 3'b000, 1'b0, 3'b000);
        run_alu("r_sub",  7'b0110011, 3'b000, 1'b1, 3'b001);
        run_alu("r_and",  7'b0110011, 3'b111, 1'b0, 3'b010);
        run_alu("r_or",   7'b0110011, 3'b110, 1'b0, 3'b011);
        run_alu("i_slt",  7'b0010011, 3'b010, 1'b0, 3'b101);
        run_alu("i_addf7", 7'b0010011, 3'b000, 1'b1, 3'b000);
        run_alu("i_sll",  7'b0010011, 3'b001, 1'b0, 3'b000);

        set_instr(7'b0000011, 3'b010, 1'b0, 2'b00);
        step("lw_fetch_wait", 1, 0, 0, e_fetch(0));
        step("lw_fetch",  1, 1, 0, e_fetch(1));
        step("lw_decode", 1, 1, 0, e_decode());
        step("lw_memadr", 1, 1, 0, e_memadr());
        for (int i = 0; i < 4; i++)
            step("lw_memread", 1, (i == 3), 0, ev(0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0));
        step("lw_memwb", 1, 1, 0, ev(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 3'b000, 1, 0));

        set_instr(7'b0100011, 3'b010, 1'b0, 2'b01);
        step("sw_fetch",  1, 1, 0, e_fetch(1));
        step("sw_decode", 1, 1, 0, e_decode());
        step("sw_memadr", 1, 1, 0, e_memadr());
        for (int i = 0; i < 3; i++)
            step("sw_memwrite", 1, (i == 2), 0,
                 ev(0, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 3'b000, (i == 2), 0));

        for (int z = 1; z >= 0; z--) begin
            set_instr(7'b1100011, 3'b000, 1'b0, 2'b10);
            step("beq_fetch",  1, 1, z[0], e_fetch(1));
            step("beq_decode", 1, 1, z[0], e_decode());
            step(z ? "beq_taken" : "beq_not_taken", 1, 1, z[0],
                 ev(z[0], 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 1, 0));
        end

        set_instr(7'b1101111, 3'b000, 1'b0, 2'b11);
        step("jal_fetch",  1, 1, 0, e_fetch(1));
        step("jal_decode", 1, 1, 0, e_decode());
        step("jal_jal",    1, 1, 0, ev(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000, 0, 0));
        step("jal_wb",     1, 1, 0, e_aluwb());

        set_instr(7'b1111111, 3'b000, 1'b0, 2'b00);
        step("ill_fetch",  1, 1, 0, e_fetch(1));
        step("ill_decode", 1, 1, 0, ev(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 1, 1));

        set_instr(7'b0100011, 3'b010, 1'b0, 2'b01);
        step("after_ill_fetch", 1, 1, 0, e_fetch(1));
        step("rst_sw_decode",   1, 1, 0, e_decode());
        step("rst_sw_memadr",   1, 1, 0, e_memadr());
        step("rst_sw_memwrite", 1, 0, 0, ev(0, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0));
        step("rst_in_memwrite", 0, 0, 0, ev(0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0));
        step("rst_then_fetch",  1, 1, 0, e_fetch(1));
        step("rst_sw2_decode",  1, 1, 0, e_decode());
        step("rst_sw2_memadr",  1, 1, 0, e_memadr());
        step("rst_sw2_memwrite", 1, 1, 0, ev(0, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 3'b000, 1, 0));

        chk("sb_drain", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
